// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: default parameters,
// FSM state encoding and instruction register-field positions.
package fetch_pkg;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_INSTR_W   = 32;
    localparam int DEF_MEM_BYTES = 1024;
    localparam int DEF_RESET_PC  = 0;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/instr_mem_bytes.sv
// Byte-addressed instruction memory: one N-byte big-endian
// combinational read port and one synchronous byte write port.
module instr_mem_bytes
    import fetch_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int INSTR_W   = DEF_INSTR_W,
    parameter int MEM_BYTES = DEF_MEM_BYTES
) (
    input  logic               CLK,
    input  logic [ADDR_W-1:0]  i_raddr,
    output logic [INSTR_W-1:0] o_rdata,
    input  logic               i_we,
    input  logic [ADDR_W-1:0]  i_waddr,
    input  logic [7:0]         i_wdata
);

    localparam int N     = INSTR_W / 8;
    localparam int IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int AW1   = ADDR_W + 1;
    localparam logic [ADDR_W:0] LIMIT = AW1'(MEM_BYTES);

    logic [7:0] r_mem [MEM_BYTES];

    // Contents are deliberately left untouched by reset.
    always_ff @(posedge CLK) begin
        if (i_we && ({1'b0, i_waddr} < LIMIT)) begin
            r_mem[i_waddr[IDX_W-1:0]] <= i_wdata;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_rd
        logic [ADDR_W-1:0] w_a;
        assign w_a = i_raddr + ADDR_W'(i);
        assign o_rdata[INSTR_W-1-8*i -: 8] =
            ({1'b0, w_a} < LIMIT) ? r_mem[w_a[IDX_W-1:0]] : 8'h00;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, redirect/stall handling,
// out-of-range halt and a sticky fault flag over a byte memory.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int          ADDR_W    = DEF_ADDR_W,
    parameter int          INSTR_W   = DEF_INSTR_W,
    parameter int          MEM_BYTES = DEF_MEM_BYTES,
    parameter int unsigned RESET_PC  = DEF_RESET_PC
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               load_en_i,
    input  logic [ADDR_W-1:0]  load_addr_i,
    input  logic [7:0]         load_data_i,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               valid_o,
    output logic [4:0]         rs_o,
    output logic [4:0]         rt_o,
    output logic [4:0]         rd_o,
    output logic               fault_o
);

    localparam int N   = INSTR_W / 8;
    localparam int AW1 = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(N);
    localparam logic [ADDR_W-1:0] ALIGN  = ADDR_W'(N - 1);
    localparam logic [ADDR_W:0]   LIMIT  = AW1'(MEM_BYTES);
    localparam logic [ADDR_W:0]   LAST   = AW1'(N - 1);
    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [ADDR_W-1:0]  r_pc_o;
    logic [ADDR_W-1:0]  w_pc_o_nxt;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] w_instr_nxt;
    logic [INSTR_W-1:0] w_rdata;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_fault;
    logic               w_fault_nxt;
    logic [ADDR_W:0]    w_last;
    logic               w_oob;
    logic               w_misalign;
    logic               w_redir;

    instr_mem_bytes #(
        .ADDR_W    (ADDR_W),
        .INSTR_W   (INSTR_W),
        .MEM_BYTES (MEM_BYTES)
    ) u_mem (
        .CLK     (CLK),
        .i_raddr (r_pc),
        .o_rdata (w_rdata),
        .i_we    (load_en_i),
        .i_waddr (load_addr_i),
        .i_wdata (load_data_i)
    );

    // Widened by one bit so a word straddling the top of memory is caught
    // without being hidden by address wrap-around.
    assign w_last     = {1'b0, r_pc} + LAST;
    assign w_oob      = (w_last >= LIMIT);
    assign w_misalign = |(redirect_pc_i & ALIGN);
    assign w_redir    = redirect_i && (r_state != BOOT);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            BOOT: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                if (redirect_i) begin
                    w_state_nxt = FETCH;
                end else if (!stall_i && w_oob) begin
                    w_state_nxt = HALT;
                end
            end
            HALT: begin
                if (redirect_i) begin
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    always_comb begin
        w_pc_nxt    = r_pc;
        w_pc_o_nxt  = r_pc_o;
        w_instr_nxt = r_instr;
        w_valid_nxt = r_valid;
        w_fault_nxt = r_fault;
        if (w_redir) begin
            w_pc_nxt    = redirect_pc_i & ~ALIGN;
            w_valid_nxt = 1'b0;
            w_fault_nxt = r_fault | w_misalign;
        end else if (r_state == FETCH && !stall_i) begin
            w_pc_o_nxt = r_pc;
            if (w_oob) begin
                w_instr_nxt = '0;
                w_valid_nxt = 1'b0;
                w_fault_nxt = 1'b1;
            end else begin
                w_instr_nxt = w_rdata;
                w_valid_nxt = 1'b1;
                w_pc_nxt    = r_pc + STEP;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pc    <= RST_PC;
            r_pc_o  <= RST_PC;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_pc_o  <= w_pc_o_nxt;
            r_instr <= w_instr_nxt;
            r_valid <= w_valid_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    assign instr_o = r_instr;
    assign pc_o    = r_pc_o;
    assign valid_o = r_valid;
    assign fault_o = r_fault;
    assign rs_o    = r_instr[RS_HI:RS_LO];
    assign rt_o    = r_instr[RT_HI:RT_LO];
    assign rd_o    = r_instr[RD_HI:RD_LO];

endmodule
